// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the memory/IO bridge.
//   - Default IO address map (IO window base, switch, output and button bases)
//   - OUT_W: width of each board output register
//   - rd_sel_e: source select for the registered load-return path
package mmio_pkg;

  localparam logic [31:0] IO_BASE_DEF  = 32'hFFFF_FC00;
  localparam logic [31:0] SW_ADDR_DEF  = 32'hFFFF_FC70;
  localparam logic [31:0] OUT_BASE_DEF = 32'hFFFF_FC7C;
  localparam logic [31:0] BTN_BASE_DEF = 32'hFFFF_FC90;

  localparam int unsigned DB_CYC_DEF = 1_000_000;

  localparam int unsigned OUT_W = 16;

  typedef enum logic {
    RD_MEM = 1'b0,
    RD_IO  = 1'b1
  } rd_sel_e;

endpackage

// File: rtl/mmio_bridge_btn_debounce.sv
// btn_debounce: conditioning for one active-high push button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw button input (asynchronous to clk)
//   db_level   : debounced level
//   rise       : one-cycle pulse in the cycle before db_level goes 0->1,
//                so a flag set from it updates on the same edge as db_level
module btn_debounce #(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db_level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_CYC + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          flip;

  // The DB_CYC-th consecutive disagreeing cycle is the one where cnt has
  // already counted DB_CYC-1 of them.
  assign flip = (sync_2 != db_level) && (cnt == CW'(DB_CYC - 1));
  assign rise = flip && sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      cnt      <= '0;
      db_level <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      if (sync_2 == db_level) begin
        cnt <= '0;
      end else if (flip) begin
        db_level <= sync_2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: bridge between the CPU datapath and data memory / board IO.
//   clk, rst_n            : clock, asynchronous active-low reset
//   mem_read, mem_write   : controller memory strobes
//   io_read, io_write     : controller IO strobes
//   addr_in, wdata        : ALU address, store data
//   mem_rdata             : data RAM output (valid the cycle after a read)
//   mem_addr, mem_wdata   : pass-through to data RAM
//   mem_we                : RAM write enable, suppressed inside the IO window
//   sw_in, btn_in         : raw switches and buttons
//   rdata                 : load result, one cycle after the request
//   out_data              : N_OUT packed 16-bit output registers
//   err                   : one-cycle pulse after an IO access to an unmapped address
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       SW_W     = 16,
  parameter int unsigned       N_BTN    = 3,
  parameter int unsigned       N_OUT    = 3,
  parameter logic [DATA_W-1:0] IO_BASE  = IO_BASE_DEF,
  parameter logic [DATA_W-1:0] SW_ADDR  = SW_ADDR_DEF,
  parameter logic [DATA_W-1:0] OUT_BASE = OUT_BASE_DEF,
  parameter logic [DATA_W-1:0] BTN_BASE = BTN_BASE_DEF,
  parameter int unsigned       DB_CYC   = DB_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   io_read,
  input  logic                   io_write,
  input  logic [DATA_W-1:0]      addr_in,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [DATA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_we,
  input  logic [SW_W-1:0]        sw_in,
  input  logic [N_BTN-1:0]       btn_in,
  output logic [DATA_W-1:0]      rdata,
  output logic [OUT_W*N_OUT-1:0] out_data,
  output logic                   err
);

  logic              is_io;
  logic              sw_hit;
  logic [N_OUT-1:0]  out_hit;
  logic [N_BTN-1:0]  btn_hit;
  logic              rd_hit;
  logic              wr_hit;
  logic              err_n;
  logic [DATA_W-1:0] io_rdata_n;
  logic [DATA_W-1:0] io_rdata_q;
  rd_sel_e           rd_sel;

  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [N_BTN-1:0]  db_level;
  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  press_flag;

  assign mem_addr  = addr_in;
  assign mem_wdata = wdata;
  assign is_io     = addr_in[DATA_W-1:10] == IO_BASE[DATA_W-1:10];
  assign mem_we    = mem_write && !is_io;

  // Address decode and IO read-data mux
  always_comb begin
    sw_hit     = is_io && (addr_in == SW_ADDR);
    out_hit    = '0;
    btn_hit    = '0;
    io_rdata_n = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      out_hit[i] = is_io && (addr_in == OUT_BASE + DATA_W'(4 * i));
    end
    for (int unsigned i = 0; i < N_BTN; i++) begin
      btn_hit[i] = is_io && (addr_in == BTN_BASE + DATA_W'(4 * i));
    end
    if (sw_hit) begin
      io_rdata_n = DATA_W'(sw_sync);
    end
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (btn_hit[i]) begin
        io_rdata_n = DATA_W'({press_flag[i], db_level[i]});
      end
    end
    rd_hit = sw_hit || (|btn_hit);
    wr_hit = |out_hit;
    err_n  = (io_read && !rd_hit) || (io_write && !wr_hit);
  end

  // Switch synchroniser (no debounce)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYC (DB_CYC)
    ) u_btn_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_in[g]),
      .db_level (db_level[g]),
      .rise     (rise[g])
    );
  end

  // A new press wins over a coinciding clearing read so no press is lost;
  // the read itself captures the pre-edge flag value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_flag <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        press_flag[i] <= rise[i] || (press_flag[i] && !(io_read && btn_hit[i]));
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (io_write) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (out_hit[i]) begin
          out_data[OUT_W*i +: OUT_W] <= wdata[OUT_W-1:0];
        end
      end
    end
  end

  // Load-return path; reset selects IO with zero data so rdata reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel     <= RD_IO;
      io_rdata_q <= '0;
      err        <= 1'b0;
    end else begin
      err <= err_n;
      if (io_read) begin
        rd_sel     <= RD_IO;
        io_rdata_q <= io_rdata_n;
      end else if (mem_read) begin
        rd_sel <= RD_MEM;
      end
    end
  end

  assign rdata = (rd_sel == RD_IO) ? io_rdata_q : mem_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW_W   = 16;
  localparam int unsigned N_BTN  = 3;
  localparam int unsigned N_OUT  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_read, mem_write, io_read, io_write;
  logic [DATA_W-1:0] addr_in, wdata, mem_rdata;
  logic [DATA_W-1:0] mem_addr, mem_wdata, rdata;
  logic              mem_we, err;
  logic [SW_W-1:0]   sw_in;
  logic [N_BTN-1:0]  btn_in;
  logic [16*N_OUT-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_err_q[$];

  typedef struct {
    string             name;
    logic [DATA_W-1:0] addr;
    logic              is_io;
    logic [DATA_W-1:0] ram;
    logic [DATA_W-1:0] exp;
    logic              exp_err;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  mmio_bridge #(
    .DATA_W (DATA_W),
    .SW_W   (SW_W),
    .N_BTN  (N_BTN),
    .N_OUT  (N_OUT),
    .DB_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .io_read   (io_read),
    .io_write  (io_write),
    .addr_in   (addr_in),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .rdata     (rdata),
    .out_data  (out_data),
    .err       (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle load; the expectation is queued now and checked when
  // the data is due, one cycle later.
  task automatic do_load(input string name, input logic [DATA_W-1:0] a, input logic io,
                         input logic [DATA_W-1:0] ram, input logic [DATA_W-1:0] exp,
                         input logic exp_err);
    logic [DATA_W-1:0] e;
    logic              ee;
    addr_in   = a;
    io_read   = io;
    mem_read  = !io;
    mem_rdata = ram;
    exp_q.push_back(exp);
    exp_err_q.push_back(exp_err);
    step();
    io_read  = 1'b0;
    mem_read = 1'b0;
    e  = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    check({name, "_rdata"}, 64'(rdata), 64'(e));
    check({name, "_err"}, 64'(err), 64'(ee));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"sw",        32'hFFFF_FC70, 1'b1, 32'hFFFF_FFFF, 32'h0000_5A5A, 1'b0};
    vecs[1] = '{"mem",       32'h0000_0040, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{"btn0_idle", 32'hFFFF_FC90, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[3] = '{"unmapped",  32'hFFFF_FC00, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[4] = '{"out_as_rd", 32'hFFFF_FC7C, 1'b1, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[5] = '{"btn2_idle", 32'hFFFF_FC98, 1'b1, 32'h2222_2222, 32'h0000_0000, 1'b0};
    vecs[6] = '{"btn3_none", 32'hFFFF_FC9C, 1'b1, 32'h3333_3333, 32'h0000_0000, 1'b1};
    vecs[7] = '{"mem2",      32'h0000_0100, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};

    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; io_read = 1'b0; io_write = 1'b0;
    addr_in = '0; wdata = '0; mem_rdata = 32'hCAFE_F00D;
    sw_in = '0; btn_in = '0;
    repeat (3) step();
    check("reset_out_data", 64'(out_data), 64'h0);
    check("reset_rdata", 64'(rdata), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    rst_n = 1'b1;
    step();

    // Stores to output registers
    io_write = 1'b1; addr_in = 32'hFFFF_FC80; wdata = 32'h1234_ABCD;
    step();
    io_write = 1'b0;
    check("store_out1", 64'(out_data), 64'h0000_ABCD_0000);
    check("store_err", 64'(err), 64'h0);
    io_write = 1'b1; addr_in = 32'hFFFF_FC84; wdata = 32'hFFFF_0042;
    step();
    io_write = 1'b0;
    check("store_out2", 64'(out_data), 64'h0042_ABCD_0000);
    io_write = 1'b1; addr_in = 32'hFFFF_FC78; wdata = 32'h0000_7777;
    step();
    io_write = 1'b0;
    check("store_bad_out", 64'(out_data), 64'h0042_ABCD_0000);
    check("store_bad_err", 64'(err), 64'h1);

    // Table-driven loads
    sw_in = 16'h5A5A;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].name, vecs[i].addr, vecs[i].is_io, vecs[i].ram, vecs[i].exp, vecs[i].exp_err);
    end

    // IO read data holds with no strobe; mem_rdata is ignored
    do_load("sw_again", 32'hFFFF_FC70, 1'b1, 32'h0BAD_0BAD, 32'h0000_5A5A, 1'b0);
    mem_rdata = 32'h7654_3210;
    step();
    check("hold_rdata", 64'(rdata), 64'h0000_5A5A);

    // Memory write enable gating
    mem_write = 1'b1; addr_in = 32'hFFFF_FC10; wdata = 32'hA5A5_0001;
    #1;
    check("mem_we_io_window", 64'(mem_we), 64'h0);
    addr_in = 32'h0000_0040;
    #1;
    check("mem_we_ram", 64'(mem_we), 64'h1);
    check("mem_addr_pass", 64'(mem_addr), 64'h0000_0040);
    check("mem_wdata_pass", 64'(mem_wdata), 64'hA5A5_0001);
    mem_write = 1'b0;
    step();

    // Unmapped IO read: err for exactly one cycle
    do_load("err_pulse", 32'hFFFF_FC00, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    step();
    check("err_one_cycle", 64'(err), 64'h0);

    // Button 1 glitch shorter than debounce window
    btn_in[1] = 1'b1;
    repeat (3) step();
    btn_in[1] = 1'b0;
    repeat (10) step();
    do_load("btn1_glitch", 32'hFFFF_FC94, 1'b1, 32'h0, 32'h0, 1'b0);

    // Button 1 held: level and flag set, then flag cleared by the read
    btn_in[1] = 1'b1;
    repeat (10) step();
    do_load("btn1_press", 32'hFFFF_FC94, 1'b1, 32'h0, 32'h3, 1'b0);
    do_load("btn1_cleared", 32'hFFFF_FC94, 1'b1, 32'h0, 32'h1, 1'b0);

    // Button 0 rising edge coinciding with the clearing read
    btn_in[0] = 1'b1;
    repeat (5) step();
    do_load("btn0_coincide", 32'hFFFF_FC90, 1'b1, 32'h0, 32'h0, 1'b0);
    do_load("btn0_kept", 32'hFFFF_FC90, 1'b1, 32'h0, 32'h3, 1'b0);
    do_load("btn0_cleared", 32'hFFFF_FC90, 1'b1, 32'h0, 32'h1, 1'b0);

    // Reset asserted in the middle of a memory load
    do_load("pre_reset_sw", 32'hFFFF_FC70, 1'b1, 32'h0, 32'h0000_5A5A, 1'b0);
    addr_in = 32'h0000_0040; mem_read = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_rdata", 64'(rdata), 64'h0);
    check("reset_mid_out", 64'(out_data), 64'h0);
    step();
    check("reset_hold_rdata", 64'(rdata), 64'h0);
    mem_read = 1'b0;
    rst_n = 1'b1;
    step();
    do_load("post_reset_mem", 32'h0000_0040, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory/IO bridge between the CPU datapath (ALU address, register-file store data, controller MemRead/MemWrite/IORead/IOWrite) and data memory plus board IO. It decodes the IO window and routes stores to data memory or to N_OUT registered 16-bit output ports (LED/seven-segment). It synchronises and debounces switches and N_BTN buttons, and keeps a read-to-clear press flag per button. Load data returns one cycle after the request for both memory and IO, matching the synchronous data RAM.

## Interface
- DATA_W, 32, datapath width
- SW_W, 16, switch bank width (SW_W ≤ DATA_W)
- N_BTN, 3, number of buttons (1..8)
- N_OUT, 3, number of 16-bit output registers (1..8)
- IO_BASE, 32'hFFFF_FC00, base of the 1 KiB IO window; decode on addr[31:10]
- SW_ADDR, 32'hFFFF_FC70, switch bank read address
- OUT_BASE, 32'hFFFF_FC7C, output register i at OUT_BASE+4*i
- BTN_BASE, 32'hFFFF_FC90, button i status at BTN_BASE+4*i
- DB_CYC, 1_000_000, debounce stability count in cycles (≥2)

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- mem_read, mem_write, io_read, io_write  in  1 each  controller strobes
- addr_in  in  DATA_W  ALU result address
- wdata  in  DATA_W  store data from register file
- mem_rdata  in  DATA_W  data RAM output, valid the cycle after the read
- mem_addr  out  DATA_W  equals addr_in (combinational)
- mem_wdata  out  DATA_W  equals wdata
- mem_we  out  1  mem_write && !is_io
- sw_in  in  SW_W  raw switches
- btn_in  in  N_BTN  raw buttons, active-high
- rdata  out  DATA_W  load result to write-back
- out_data  out  16*N_OUT  output registers; register i at [16i+15:16i]
- err  out  1  one-cycle pulse on an IO access to an unmapped address

## Operation
- is_io = addr_in[31:10] == IO_BASE[31:10]. A memory write into the IO window is blocked: mem_we = 0.
- IO write (io_write && is_io) to OUT_BASE+4i: out_reg[i] ← wdata[15:0] at the clock edge. Other IO writes are ignored and pulse err.
- IO read sources:
  - SW_ADDR → zero-extended sw_sync.
  - BTN_BASE+4i → {30'b0, press_flag[i], db_level[i]}.
  - Unmapped → 0, and err pulses.
- Switch path: two-flop synchroniser. No debounce.
- Button path (per button):
  - Two-flop synchroniser, then a debounce counter.
  - db_level takes the synced value after DB_CYC consecutive cycles of disagreement with the current level. Any agreement resets the counter.
  - On a 0→1 transition of db_level, press_flag is set.
  - An IO read of that button's address clears press_flag on the same edge that captures it.
  - If a new rising edge coincides with the clearing read, the flag stays 1 (no lost press); the read returns the old value.
- Simultaneous io_read and io_write in one cycle: both take effect. Read data is the pre-write value.

## Timing
- Load latency is 1 cycle. At edge T the bridge registers rd_sel (io/mem) and io_rdata. During T+1: rdata = rd_sel ? io_rdata_q : mem_rdata.
- With no read strobe, rd_sel and io_rdata_q hold.
- Outputs at reset: out_data = 0, rdata = 0 (rd_sel = io, io_rdata_q = 0), err = 0.
- Internal state at reset: db_level = 0, press_flag = 0, synchronisers = 0, debounce counters = 0.
- Input-to-level latency:
  - Switch change is visible to a read 2 cycles after the change.
  - Button level is visible after 2 + DB_CYC cycles.
- Reset is asynchronous. Asserting it mid-debounce discards the count. Asserting it mid-load makes rdata 0 during the following cycle.
- Output register writes are visible on out_data the cycle after the store.
- err is registered and high for exactly one cycle, the cycle after the offending access.

## Structure
- Package mmio_pkg holds:
  - default address constants (IO_BASE, SW_ADDR, OUT_BASE, BTN_BASE);
  - the OUT_W = 16 constant;
  - the rd_sel encoding.
- Sub-module btn_debounce handles one button: synchroniser, counter of width $clog2(DB_CYC+1), db_level, and a rising-edge pulse output. mmio_bridge instantiates it N_BTN times.
- Press flags, output registers, the read mux and the error logic live in mmio_bridge.

## Test plan
- Reset, then a store of 0x1234_ABCD to 0xFFFF_FC80 with io_write → out_data[31:16] = 0xABCD next cycle; other registers stay 0.
- sw_in = 0x5A5A, wait 3 cycles, load 0xFFFF_FC70 → rdata = 0x0000_5A5A the cycle after the load; mem_rdata is ignored.
- DB_CYC = 4: hold btn_in[1] high 3 cycles then low (glitch) → db_level stays 0. Hold it 10 cycles → a load of 0xFFFF_FC94 returns 0x3; a second load returns 0x1 (flag cleared).
- Rising debounced edge on button 0 in the same cycle as a load of 0xFFFF_FC90 → that load returns the old flag; the next load returns bit1 = 1.
- mem_write to 0xFFFF_FC10 → mem_we = 0. io_read of 0xFFFF_FC00 → rdata = 0 and err high for exactly one cycle.
- mem_read at 0x0000_0040 with RAM returning 0xDEAD_BEEF, rst_n pulsed low mid-sequence → rdata = 0 during reset; after release, a load returns 0xDEAD_BEEF.
